// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch bridge: one-line buffer in front of a req/ack instruction memory.
// Hits return combinationally; misses stall the core and fill the line sequentially.
module inst_fetch_bridge #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        stall_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int OFF_W = CNT_W + 2;
  localparam int TAG_W = 32 - OFF_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_t;

  state_t            r_state;
  logic [31:0]       r_buf [LINE_WORDS];
  logic [TAG_W-1:0]  r_tag;
  logic [TAG_W-1:0]  r_fill_tag;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_discard;
  logic              r_mem_req;
  logic [31:0]       r_mem_addr;

  logic              w_hit;
  logic [TAG_W-1:0]  w_addr_tag;
  logic [CNT_W-1:0]  w_addr_word;
  logic              w_unused;

  assign w_addr_tag  = rom_addr_i[31:OFF_W];
  assign w_addr_word = rom_addr_i[OFF_W-1:2];
  assign w_unused    = ^rom_addr_i[1:0];

  // A hit is only honoured in IDLE so the core never sees a half-filled line.
  assign w_hit      = r_valid && (w_addr_tag == r_tag) && (r_state == ST_IDLE);
  assign rom_data_o = (w_hit && rom_ce_i) ? r_buf[w_addr_word] : 32'h0;
  assign stall_o    = rom_ce_i && !w_hit;
  assign mem_req_o  = r_mem_req;
  assign mem_addr_o = r_mem_addr;

  // Line storage carries no reset; valid gates every read of it.
  always_ff @(posedge clk) begin
    if (r_state == ST_FILL && mem_ack_i) begin
      r_buf[r_cnt] <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_tag      <= '0;
      r_fill_tag <= '0;
      r_valid    <= 1'b0;
      r_cnt      <= '0;
      r_discard  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush_i) begin
            r_valid <= 1'b0;
          end else if (rom_ce_i && !w_hit) begin
            r_state    <= ST_FILL;
            r_fill_tag <= w_addr_tag;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_discard  <= 1'b0;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {w_addr_tag, OFF_W'(0)};
          end
        end
        ST_FILL: begin
          // A flush during the fill cannot abort it, so remember to drop the line.
          if (flush_i) begin
            r_discard <= 1'b1;
          end
          if (mem_ack_i) begin
            r_cnt      <= r_cnt + 1'b1;
            r_mem_addr <= r_mem_addr + 32'd4;
            if (r_cnt == LAST_BEAT) begin
              r_state    <= ST_IDLE;
              r_mem_req  <= 1'b0;
              r_mem_addr <= 32'h0;
              r_tag      <= r_fill_tag;
              r_valid    <= !r_discard && !flush_i;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge with a small req/ack memory model.
module tb_inst_fetch_bridge;

  logic        clk;
  logic        rstN;
  logic        romCe;
  logic [31:0] romAddr;
  logic [31:0] romData;
  logic        stall;
  logic        flush;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memRdata;

  logic        ackEnable;
  logic        ackForce;
  int          ackDelay;
  int          waitCnt;
  logic [31:0] dataOffset;

  int nChecks;
  int nPassed;
  int stallCycles;

  inst_fetch_bridge #(.LINE_WORDS(4)) dut (
    .clk        (clk),
    .rst        (rstN),
    .rom_ce_i   (romCe),
    .rom_addr_i (romAddr),
    .rom_data_o (romData),
    .stall_o    (stall),
    .flush_i    (flush),
    .mem_req_o  (memReq),
    .mem_addr_o (memAddr),
    .mem_ack_i  (memAck),
    .mem_rdata_i(memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks ackDelay cycles after the request/address appears.
  always @(posedge clk) begin
    if (!memReq || memAck) waitCnt <= 0;
    else                   waitCnt <= waitCnt + 1;
  end

  assign memAck   = ackForce | (ackEnable & memReq & (waitCnt == ackDelay));
  assign memRdata = memAddr + dataOffset;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) nPassed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ce, input logic [31:0] addr);
    romCe   = ce;
    romAddr = addr;
    #1;
  endtask

  task automatic countStall(output int n);
    n = 0;
    while (stall && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    logic [31:0] beatAddr;
    nChecks    = 0;
    nPassed    = 0;
    waitCnt    = 0;
    rstN       = 1'b0;
    romCe      = 1'b1;
    romAddr    = 32'h0;
    flush      = 1'b0;
    ackEnable  = 1'b0;
    ackForce   = 1'b0;
    ackDelay   = 0;
    dataOffset = 32'h1000;

    // Reset held with fetch enabled and a stray ack pulse.
    #3;
    ackForce = 1'b1;
    tick();
    tick();
    checkOutput("rst_req", {31'h0, memReq}, 32'h0);
    checkOutput("rst_addr", memAddr, 32'h0);
    checkOutput("rst_data", romData, 32'h0);
    checkOutput("rst_stall", {31'h0, stall}, 32'h1);
    ackForce = 1'b0;

    // Release and cold miss at 0x0.
    rstN = 1'b1;
    #1;
    checkOutput("cold_stall0", {31'h0, stall}, 32'h1);
    tick();
    checkOutput("cold_fill_req", {31'h0, memReq}, 32'h1);
    ackEnable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beatAddr = 32'(i * 4);
      checkOutput("cold_beat_addr", memAddr, beatAddr);
      checkOutput("cold_beat_stall", {31'h0, stall}, 32'h1);
      tick();
    end
    checkOutput("cold_done_stall", {31'h0, stall}, 32'h0);
    checkOutput("cold_done_req", {31'h0, memReq}, 32'h0);
    checkOutput("cold_data0", romData, 32'h1000);
    applyStimulus(1'b1, 32'h4);
    checkOutput("hit_data4", romData, 32'h1004);
    tick();
    applyStimulus(1'b1, 32'h8);
    checkOutput("hit_data8", romData, 32'h1008);
    checkOutput("hit_stall8", {31'h0, stall}, 32'h0);
    tick();
    applyStimulus(1'b1, 32'hC);
    checkOutput("hit_dataC", romData, 32'h100C);
    checkOutput("hit_req", {31'h0, memReq}, 32'h0);

    // Line change to 0x10 and back to 0x0.
    applyStimulus(1'b1, 32'h10);
    countStall(stallCycles);
    checkOutput("line10_stall_cycles", 32'(stallCycles), 32'd5);
    checkOutput("line10_data", romData, 32'h1010);
    applyStimulus(1'b1, 32'h0);
    checkOutput("line0_remiss", {31'h0, stall}, 32'h1);
    countStall(stallCycles);
    checkOutput("line0_stall_cycles", 32'(stallCycles), 32'd5);
    checkOutput("line0_data", romData, 32'h1000);

    // Slow memory: ack two cycles after each request.
    ackDelay = 2;
    applyStimulus(1'b1, 32'h0040_0010);
    checkOutput("slow_stall0", {31'h0, stall}, 32'h1);
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 3; k++) begin
        beatAddr = 32'h0040_0010 + 32'(b * 4);
        checkOutput("slow_beat_addr", memAddr, beatAddr);
        checkOutput("slow_beat_stall", {31'h0, stall}, 32'h1);
        tick();
      end
    end
    checkOutput("slow_done_stall", {31'h0, stall}, 32'h0);
    checkOutput("slow_data", romData, 32'h0040_1010);
    ackDelay = 0;

    // Flush on the third beat of a fill: fill completes, line discarded, refill.
    applyStimulus(1'b1, 32'h20);
    tick();
    checkOutput("fl_beat0", memAddr, 32'h20);
    tick();
    tick();
    checkOutput("fl_beat2", memAddr, 32'h28);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("fl_beat3", memAddr, 32'h2C);
    checkOutput("fl_beat3_req", {31'h0, memReq}, 32'h1);
    tick();
    checkOutput("fl_idle_req", {31'h0, memReq}, 32'h0);
    checkOutput("fl_discard_stall", {31'h0, stall}, 32'h1);
    dataOffset = 32'h2000;
    tick();
    checkOutput("fl_refill_req", {31'h0, memReq}, 32'h1);
    checkOutput("fl_refill_addr", memAddr, 32'h20);
    countStall(stallCycles);
    checkOutput("fl_refill_cycles", 32'(stallCycles), 32'd4);
    checkOutput("fl_refill_data", romData, 32'h2020);

    // Flush in IDLE on a hit, then hold flush over a miss: no fill may start.
    flush = 1'b1;
    #1;
    checkOutput("idlefl_hit_stall", {31'h0, stall}, 32'h0);
    tick();
    checkOutput("idlefl_miss_stall", {31'h0, stall}, 32'h1);
    tick();
    checkOutput("idlefl_no_fill", {31'h0, memReq}, 32'h0);
    flush = 1'b0;
    tick();
    checkOutput("idlefl_fill_req", {31'h0, memReq}, 32'h1);
    checkOutput("idlefl_fill_addr", memAddr, 32'h20);
    countStall(stallCycles);
    checkOutput("idlefl_fill_cycles", 32'(stallCycles), 32'd4);
    checkOutput("idlefl_data", romData, 32'h2024 - 32'h4);

    // Fetch disabled with a stale (missing) address and with a hitting one.
    applyStimulus(1'b0, 32'h1230);
    checkOutput("ce0_stall", {31'h0, stall}, 32'h0);
    checkOutput("ce0_data", romData, 32'h0);
    tick();
    tick();
    checkOutput("ce0_no_req", {31'h0, memReq}, 32'h0);
    applyStimulus(1'b0, 32'h24);
    checkOutput("ce0_hit_data", romData, 32'h0);

    // Reset asserted mid-fill, then refill from offset 0.
    applyStimulus(1'b1, 32'h48);
    tick();
    tick();
    checkOutput("midrst_beat1", memAddr, 32'h44);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_req", {31'h0, memReq}, 32'h0);
    checkOutput("midrst_addr", memAddr, 32'h0);
    checkOutput("midrst_stall", {31'h0, stall}, 32'h1);
    rstN = 1'b1;
    tick();
    checkOutput("midrst_refill_addr", memAddr, 32'h40);
    countStall(stallCycles);
    checkOutput("midrst_refill_cycles", 32'(stallCycles), 32'd4);
    checkOutput("midrst_data", romData, 32'h2048);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
